// File: rtl/ysyx_20020207_axi_pkg.sv
// Shared definitions for the IFU/LSU AXI arbiter: FSM encodings,
// requester IDs and AXI response codes.
package ysyx_20020207_axi_pkg;

  // Read-side arbiter FSM: one outstanding read, owner encoded in the state.
  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_IFU_AR = 3'd1,
    R_IFU_R  = 3'd2,
    R_LSU_AR = 3'd3,
    R_LSU_R  = 3'd4
  } rd_state_e;

  // Write-side FSM: only the LSU writes, AW and W may complete in any order.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // Requester IDs double as the bit index into the 2-bit request/grant vectors.
  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_20020207_rr_arb2.sv
// Two-way round-robin picker: a lone request always wins, a tie goes to the
// requester that was not granted last time.
module ysyx_20020207_rr_arb2
  import ysyx_20020207_axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Pick a one-hot winner from the request vector and the last-granted ID.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == ID_IFU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_20020207_axi_arbiter.sv
// Arbitrates IFU and LSU onto a single AXI master port toward the XBAR.
// Reads from both requesters share one read FSM (round-robin, one outstanding);
// LSU writes run on an independent write FSM so reads and writes overlap.
module ysyx_20020207_axi_arbiter
  import ysyx_20020207_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read port
  input  logic                ifu_arvalid,
  input  logic                ifu_rready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_arready,
  output logic                ifu_rvalid,
  output logic [1:0]          ifu_rresp,
  output logic [DATA_W-1:0]   ifu_rdata,
  // LSU read/write port
  input  logic                lsu_arvalid,
  input  logic                lsu_rready,
  input  logic                lsu_awvalid,
  input  logic                lsu_wvalid,
  input  logic                lsu_bready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  output logic                lsu_awready,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_rresp,
  output logic [1:0]          lsu_bresp,
  output logic [DATA_W-1:0]   lsu_rdata,
  // Master port toward the XBAR
  output logic                arvalid,
  output logic                rready,
  output logic                awvalid,
  output logic                wvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                arready,
  input  logic                rvalid,
  input  logic                awready,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          rresp,
  input  logic [1:0]          bresp,
  input  logic [DATA_W-1:0]   rdata
);

  localparam int STRB_W = DATA_W / 8;

  rd_state_e  rd_state_r, rd_state_s;
  wr_state_e  wr_state_r, wr_state_s;
  logic       last_rd_r;
  logic       aw_done_r, w_done_r;
  logic       aw_hs_s, w_hs_s;
  logic [1:0] rd_req_s, rd_grant_s;
  logic       rd_grant_en_s;

  assign rd_req_s      = {lsu_arvalid, ifu_arvalid};
  assign rd_grant_en_s = (rd_state_r == R_IDLE) && (rd_grant_s != 2'b00) && !rst;

  ysyx_20020207_rr_arb2 u_rr_arb2 (
    .req   (rd_req_s),
    .last  (last_rd_r),
    .grant (rd_grant_s)
  );

  // Read FSM state and round-robin history; history moves only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_r <= R_IDLE;
      last_rd_r  <= ID_IFU;
    end else begin
      rd_state_r <= rd_state_s;
      if (rd_grant_en_s) begin
        last_rd_r <= rd_grant_s[ID_LSU];
      end
    end
  end

  // Read next-state and channel routing; reset forces every output low.
  always_comb begin
    rd_state_s  = rd_state_r;
    arvalid     = 1'b0;
    araddr      = {ADDR_W{1'b0}};
    rready      = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rresp   = RESP_OKAY;
    ifu_rdata   = {DATA_W{1'b0}};
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rresp   = RESP_OKAY;
    lsu_rdata   = {DATA_W{1'b0}};
    if (rst) begin
      rd_state_s = R_IDLE;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (rd_grant_s[ID_LSU]) begin
            rd_state_s = R_LSU_AR;
          end else if (rd_grant_s[ID_IFU]) begin
            rd_state_s = R_IFU_AR;
          end else begin
            rd_state_s = R_IDLE;
          end
        end
        R_IFU_AR: begin
          arvalid     = ifu_arvalid;
          araddr      = ifu_araddr;
          ifu_arready = arready;
          if (ifu_arvalid && arready) begin
            rd_state_s = R_IFU_R;
          end else begin
            rd_state_s = R_IFU_AR;
          end
        end
        R_IFU_R: begin
          ifu_rvalid = rvalid;
          ifu_rresp  = rresp;
          ifu_rdata  = rdata;
          rready     = ifu_rready;
          if (rvalid && ifu_rready) begin
            rd_state_s = R_IDLE;
          end else begin
            rd_state_s = R_IFU_R;
          end
        end
        R_LSU_AR: begin
          arvalid     = lsu_arvalid;
          araddr      = lsu_araddr;
          lsu_arready = arready;
          if (lsu_arvalid && arready) begin
            rd_state_s = R_LSU_R;
          end else begin
            rd_state_s = R_LSU_AR;
          end
        end
        R_LSU_R: begin
          lsu_rvalid = rvalid;
          lsu_rresp  = rresp;
          lsu_rdata  = rdata;
          rready     = lsu_rready;
          if (rvalid && lsu_rready) begin
            rd_state_s = R_IDLE;
          end else begin
            rd_state_s = R_LSU_R;
          end
        end
        default: rd_state_s = R_IDLE;
      endcase
    end
  end

  // Write FSM state and per-channel completion flags, cleared on entering W_RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= W_IDLE;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
    end else begin
      wr_state_r <= wr_state_s;
      if ((wr_state_r == W_REQ) && (wr_state_s == W_RESP)) begin
        aw_done_r <= 1'b0;
        w_done_r  <= 1'b0;
      end else begin
        aw_done_r <= aw_done_r | aw_hs_s;
        w_done_r  <= w_done_r | w_hs_s;
      end
    end
  end

  // Write next-state and routing; a channel's valid is masked once it has handshaken.
  always_comb begin
    wr_state_s  = wr_state_r;
    aw_hs_s     = 1'b0;
    w_hs_s      = 1'b0;
    awvalid     = 1'b0;
    awaddr      = {ADDR_W{1'b0}};
    wvalid      = 1'b0;
    wdata       = {DATA_W{1'b0}};
    wstrb       = {STRB_W{1'b0}};
    bready      = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = RESP_OKAY;
    if (rst) begin
      wr_state_s = W_IDLE;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (lsu_awvalid || lsu_wvalid) begin
            wr_state_s = W_REQ;
          end else begin
            wr_state_s = W_IDLE;
          end
        end
        W_REQ: begin
          awvalid     = lsu_awvalid & ~aw_done_r;
          awaddr      = lsu_awaddr;
          lsu_awready = awready & ~aw_done_r;
          wvalid      = lsu_wvalid & ~w_done_r;
          wdata       = lsu_wdata;
          wstrb       = lsu_wstrb;
          lsu_wready  = wready & ~w_done_r;
          aw_hs_s     = lsu_awvalid & awready & ~aw_done_r;
          w_hs_s      = lsu_wvalid & wready & ~w_done_r;
          if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
            wr_state_s = W_RESP;
          end else begin
            wr_state_s = W_REQ;
          end
        end
        W_RESP: begin
          lsu_bvalid = bvalid;
          lsu_bresp  = bresp;
          bready     = lsu_bready;
          if (bvalid && lsu_bready) begin
            wr_state_s = W_IDLE;
          end else begin
            wr_state_s = W_RESP;
          end
        end
        default: wr_state_s = W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_20020207_axi_arbiter.sv
// Directed self-checking bench for ysyx_20020207_axi_arbiter. The bench plays
// both requesters and the slave side; expected values are hand-computed.
module tb_ysyx_20020207_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_arvalid, ifu_rready;
  logic [31:0] ifu_araddr;
  logic        ifu_arready, ifu_rvalid;
  logic [1:0]  ifu_rresp;
  logic [63:0] ifu_rdata;
  logic        lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready;
  logic [31:0] lsu_araddr, lsu_awaddr;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wstrb;
  logic        lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
  logic [1:0]  lsu_rresp, lsu_bresp;
  logic [63:0] lsu_rdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [31:0] araddr, awaddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [1:0]  rresp, bresp;
  logic [63:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_20020207_axi_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_rready(ifu_rready), .ifu_araddr(ifu_araddr),
    .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rresp(ifu_rresp),
    .ifu_rdata(ifu_rdata),
    .lsu_arvalid(lsu_arvalid), .lsu_rready(lsu_rready), .lsu_awvalid(lsu_awvalid),
    .lsu_wvalid(lsu_wvalid), .lsu_bready(lsu_bready), .lsu_araddr(lsu_araddr),
    .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_awready(lsu_awready),
    .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_rresp(lsu_rresp),
    .lsu_bresp(lsu_bresp), .lsu_rdata(lsu_rdata),
    .arvalid(arvalid), .rready(rready), .awvalid(awvalid), .wvalid(wvalid),
    .bready(bready), .araddr(araddr), .awaddr(awaddr), .wdata(wdata), .wstrb(wstrb),
    .arready(arready), .rvalid(rvalid), .awready(awready), .wready(wready),
    .bvalid(bvalid), .rresp(rresp), .bresp(bresp), .rdata(rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_arvalid = 1'b0; ifu_araddr = 32'h0; ifu_rready = 1'b1;
    lsu_arvalid = 1'b0; lsu_araddr = 32'h0; lsu_rready = 1'b1;
    lsu_awvalid = 1'b0; lsu_awaddr = 32'h0; lsu_wvalid = 1'b0;
    lsu_wdata = 64'h0; lsu_wstrb = 8'h0; lsu_bready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 64'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  // Two reset cycles; returns in the first cycle after rst is released.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    #1;
    check("rst_arvalid", {63'h0, arvalid}, 64'h0);
    check("rst_ifu_rvalid", {63'h0, ifu_rvalid}, 64'h0);
    check("rst_awvalid", {63'h0, awvalid}, 64'h0);
    tick();
    rst = 1'b0;
  endtask

  // Called in an idle cycle with the owner's arvalid already driven: expects
  // the grant on the next edge, then AR handshake, one wait cycle, R beat.
  task automatic rd_txn(input logic is_lsu, input logic [31:0] addr, input logic [63:0] data);
    tick();
    arready = 1'b1;
    #1;
    check("ar_arvalid", {63'h0, arvalid}, 64'h1);
    check("ar_araddr", {32'h0, araddr}, {32'h0, addr});
    check("ar_own_arready", {63'h0, (is_lsu ? lsu_arready : ifu_arready)}, 64'h1);
    check("ar_oth_arready", {63'h0, (is_lsu ? ifu_arready : lsu_arready)}, 64'h0);
    tick();
    arready = 1'b0;
    if (is_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    #1;
    check("r_wait_arvalid", {63'h0, arvalid}, 64'h0);
    check("r_wait_rready", {63'h0, rready}, 64'h1);
    tick();
    rvalid = 1'b1; rdata = data; rresp = 2'b00;
    #1;
    check("r_own_rvalid", {63'h0, (is_lsu ? lsu_rvalid : ifu_rvalid)}, 64'h1);
    check("r_own_rdata", (is_lsu ? lsu_rdata : ifu_rdata), data);
    check("r_oth_rvalid", {63'h0, (is_lsu ? ifu_rvalid : lsu_rvalid)}, 64'h0);
    check("r_oth_rdata", (is_lsu ? ifu_rdata : lsu_rdata), 64'h0);
    tick();
    rvalid = 1'b0; rdata = 64'h0;
    #1;
    check("r_done_rvalid", {63'h0, (is_lsu ? lsu_rvalid : ifu_rvalid)}, 64'h0);
    check("r_done_arvalid", {63'h0, arvalid}, 64'h0);
  endtask

  initial begin
    // IFU-only read.
    do_reset();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000;
    #1;
    check("idle_arvalid", {63'h0, arvalid}, 64'h0);
    check("idle_ifu_arready", {63'h0, ifu_arready}, 64'h0);
    rd_txn(1'b0, 32'h3000_0000, 64'h1111_2222_3333_4444);

    // Tie after reset: LSU, then IFU, then tie again goes to LSU.
    do_reset();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1000;
    rd_txn(1'b1, 32'h8000_1000, 64'hAAAA_0000_0000_0001);
    rd_txn(1'b0, 32'h8000_0000, 64'hBBBB_0000_0000_0002);
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0040;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000;
    rd_txn(1'b1, 32'h8000_2000, 64'hCCCC_0000_0000_0003);
    rd_txn(1'b0, 32'h8000_0040, 64'hDDDD_0000_0000_0004);

    // Write with the W handshake two cycles before AW.
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h0f00_0000;
    lsu_wvalid = 1'b1; lsu_wdata = 64'h0123_4567_89ab_cdef; lsu_wstrb = 8'hff;
    lsu_bready = 1'b1;
    #1;
    check("w_idle_awvalid", {63'h0, awvalid}, 64'h0);
    check("w_idle_wvalid", {63'h0, wvalid}, 64'h0);
    tick();
    wready = 1'b1;
    #1;
    check("w_req_wvalid", {63'h0, wvalid}, 64'h1);
    check("w_req_wdata", wdata, 64'h0123_4567_89ab_cdef);
    check("w_req_lsu_wready", {63'h0, lsu_wready}, 64'h1);
    check("w_req_awaddr", {32'h0, awaddr}, 64'h0f00_0000);
    tick();
    wready = 1'b0;
    #1;
    check("w_after_hs_wvalid", {63'h0, wvalid}, 64'h0);
    check("w_after_hs_awvalid", {63'h0, awvalid}, 64'h1);
    tick();
    awready = 1'b1; wready = 1'b1;
    #1;
    check("aw_hs_lsu_awready", {63'h0, lsu_awready}, 64'h1);
    check("aw_hs_lsu_wready", {63'h0, lsu_wready}, 64'h0);
    check("aw_hs_wvalid", {63'h0, wvalid}, 64'h0);
    tick();
    awready = 1'b0; wready = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    bvalid = 1'b1; bresp = 2'b00;
    #1;
    check("b_lsu_bvalid", {63'h0, lsu_bvalid}, 64'h1);
    check("b_lsu_bresp", {62'h0, lsu_bresp}, 64'h0);
    check("b_bready", {63'h0, bready}, 64'h1);
    tick();
    #1;
    check("b_done_lsu_bvalid", {63'h0, lsu_bvalid}, 64'h0);
    check("b_done_bready", {63'h0, bready}, 64'h0);
    bvalid = 1'b0;

    // Concurrent LSU write and IFU read, distinct resp codes on each side.
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0100;
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h0f00_0008;
    lsu_wvalid = 1'b1; lsu_wdata = 64'h5555_6666_7777_8888; lsu_wstrb = 8'h0f;
    tick();
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    #1;
    check("cc_ifu_arready", {63'h0, ifu_arready}, 64'h1);
    check("cc_lsu_arready", {63'h0, lsu_arready}, 64'h0);
    check("cc_lsu_awready", {63'h0, lsu_awready}, 64'h1);
    check("cc_wstrb", {56'h0, wstrb}, 64'h0f);
    tick();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    ifu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    rvalid = 1'b1; rdata = 64'h9999_aaaa_bbbb_cccc; rresp = 2'b01;
    bvalid = 1'b1; bresp = 2'b10;
    #1;
    check("cc_ifu_rdata", ifu_rdata, 64'h9999_aaaa_bbbb_cccc);
    check("cc_ifu_rresp", {62'h0, ifu_rresp}, 64'h1);
    check("cc_lsu_rvalid", {63'h0, lsu_rvalid}, 64'h0);
    check("cc_lsu_rdata", lsu_rdata, 64'h0);
    check("cc_lsu_bvalid", {63'h0, lsu_bvalid}, 64'h1);
    check("cc_lsu_bresp", {62'h0, lsu_bresp}, 64'h2);
    tick();
    rvalid = 1'b0; rdata = 64'h0; rresp = 2'b00; bvalid = 1'b0; bresp = 2'b00;
    #1;
    check("cc_done_ifu_rvalid", {63'h0, ifu_rvalid}, 64'h0);
    check("cc_done_lsu_bvalid", {63'h0, lsu_bvalid}, 64'h0);

    // Reset while the IFU read sits in its R phase with rvalid pending.
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0200;
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0; ifu_arvalid = 1'b0;
    rvalid = 1'b1; rdata = 64'hdead_beef_dead_beef; rst = 1'b1;
    #1;
    check("mid_rst_ifu_rvalid", {63'h0, ifu_rvalid}, 64'h0);
    check("mid_rst_ifu_rdata", ifu_rdata, 64'h0);
    check("mid_rst_rready", {63'h0, rready}, 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ifu_rvalid", {63'h0, ifu_rvalid}, 64'h0);
    check("post_rst_rready", {63'h0, rready}, 64'h0);
    check("post_rst_arvalid", {63'h0, arvalid}, 64'h0);
    rvalid = 1'b0; rdata = 64'h0;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0300;
    rd_txn(1'b0, 32'h3000_0300, 64'h0f0f_0f0f_1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
